// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared 7-segment constants: hex glyph table, blank pattern and a
//           pin-polarity helper used by the display blocks.
// Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // One segment pattern, bit order {g,f,e,d,c,b,a}, active-high
  typedef logic [6:0] seg_pattern_t;

  // Largest digit bank the scanner is intended to drive
  localparam int MAX_DIGITS = 16;

  // All segments off (active-high view)
  localparam seg_pattern_t SEG_BLANK = 7'h00;

  // Hex glyphs indexed by nibble value; entry 15 is listed first
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Converts an active-high pattern to pin level for the chosen polarity
  function automatic seg_pattern_t seg_polarity(seg_pattern_t pat, logic active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seg7
// Brief   : Combinational nibble to 7-segment (gfedcba, active-high) decoder.
// Rev     : 1.0  initial release
// ============================================================================
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import seg7_pkg::*;

  // Table lookup; polarity is applied by whoever owns the pins
  assign seg = SEG_HEX[nibble];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scanner
// Brief   : Multiplexed N-digit hex display driver with double-buffered
//           loading, per-digit decimal points, digit enables, leading-zero
//           blanking and PWM brightness with a built-in dead phase.
// Rev     : 1.0  initial release
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8,   // 1..16
  parameter int SCAN_DIV_W = 17,  // slot length = 2^SCAN_DIV_W clocks
  parameter int BRIGHT_W   = 4,   // must not exceed SCAN_DIV_W
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);
  import seg7_pkg::*;

  localparam int              IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);
  localparam logic            c_inv      = (ACTIVE_LOW != 0);

  // Scan timing
  logic [SCAN_DIV_W-1:0] r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_presc_max;
  logic                  w_wrap;

  // Double buffer: shadow takes loads, active feeds the display
  logic [4*NUM_DIGITS-1:0] r_sh_val;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_pending;
  logic                    r_frame_start;

  // Current-digit datapath
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_en_sel;
  logic                  w_blank_sel;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_zero_run;
  logic [BRIGHT_W-1:0]   w_phase;
  logic                  w_lit;
  logic [6:0]            w_seg_pat;
  logic [NUM_DIGITS-1:0] w_an_hi;

  // Registered pins
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  assign w_presc_max = &r_presc;
  assign w_wrap      = w_presc_max && (r_idx == c_last_idx);

  // Free-running prescaler; digit index steps at the end of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (w_presc_max) begin
        r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow capture, tear-free transfer at frame wrap, frame pulse.
  // A load on the wrap cycle keeps pending set so it lands next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_val      <= '0;
      r_sh_dp       <= '0;
      r_act_val     <= '0;
      r_act_dp      <= '0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      if (w_wrap && r_pending) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
      end
      if (load) begin
        r_sh_val  <= value;
        r_sh_dp   <= dp_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Mux out the nibble, dp, enable and blank flag of the scanned digit
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_en_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_act_val[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_en_sel    = digit_en[i];
        w_blank_sel = w_blank[i];
      end
    end
  end

  // Leading-zero mask: a run of zero nibbles from the top digit down,
  // stopping above digit 0 so a value of zero still shows "0"
  always_comb begin
    w_blank    = '0;
    w_zero_run = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (r_act_val[4*i +: 4] == 4'h0);
      w_blank[i] = w_zero_run;
    end
  end

  // PWM phase is the top of the prescaler; the last phase can never be
  // below any brightness code, giving a dark gap between digits
  assign w_phase = r_presc[SCAN_DIV_W-1 -: BRIGHT_W];
  assign w_lit   = (w_phase < brightness) && w_en_sel && !w_blank_sel;

  hex_to_seg7 u_dec (
    .nibble (w_nib),
    .seg    (w_seg_pat)
  );

  // One-hot anode for the scanned digit when lit, otherwise none
  always_comb begin
    w_an_hi = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_hi[i] = w_lit && (r_idx == IDX_W'(i));
    end
  end

  // Output register with polarity applied; resets to all-inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= {NUM_DIGITS{c_inv}};
      r_seg <= seg_polarity(SEG_BLANK, c_inv);
      r_dp  <= c_inv;
    end else begin
      r_an  <= w_an_hi ^ {NUM_DIGITS{c_inv}};
      r_seg <= seg_polarity(w_lit ? w_seg_pat : SEG_BLANK, c_inv);
      r_dp  <= (w_lit & w_dp_sel) ^ c_inv;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign pending     = r_pending;
  assign frame_start = r_frame_start;

endmodule : seven_seg_scanner
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scanner
// Brief   : Self-checking bench for seven_seg_scanner (4 digits, 16-cycle
//           slots, 2-bit brightness), active-low and active-high instances.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;
  localparam int ND = 4;
  localparam int SW = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          load;
  logic [3:0]    digit_en;
  logic          blank_lz;
  logic [BW-1:0] brightness;

  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h;
  logic [3:0] an_l, an_h;
  logic       pend_l, pend_h;
  logic       fs_l, fs_h;

  int checks   = 0;
  int failures = 0;

  // Reference model state: frame position 0..63, buffers, pending
  int          p;
  logic [15:0] m_sh_val, m_act_val;
  logic [3:0]  m_sh_dp, m_act_dp;
  bit          m_pend, m_fs;
  logic [3:0]  e_an, e_an_l;
  logic [6:0]  e_seg, e_seg_l;
  logic        e_dp, e_dp_l;
  int          cnt;

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV_W(SW), .BRIGHT_W(BW), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg_l), .dp(dp_l), .an(an_l), .pending(pend_l), .frame_start(fs_l));

  seven_seg_scanner #(.NUM_DIGITS(ND), .SCAN_DIV_W(SW), .BRIGHT_W(BW), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
    .seg(seg_h), .dp(dp_h), .an(an_h), .pending(pend_h), .frame_start(fs_h));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = 0; m_sh_val = '0; m_act_val = '0; m_sh_dp = '0; m_act_dp = '0;
    m_pend = 0; m_fs = 0;
  endtask

  // Digit d is blanked when enabled and it and every digit above it are zero
  function automatic bit is_blanked(int d);
    if (!blank_lz || d == 0) return 0;
    for (int j = d; j < ND; j++)
      if (m_act_val[j*4 +: 4] != 4'h0) return 0;
    return 1;
  endfunction

  // One clock: predict pins from the pre-edge state, advance model, compare
  task automatic step();
    int d, ph;
    bit lit;
    @(posedge clk);
    d   = p / 16;
    ph  = (p % 16) / 4;
    lit = (ph < int'(brightness)) && digit_en[d] && !is_blanked(d);
    e_an    = lit ? 4'(1 << d) : 4'h0;
    e_seg   = lit ? HEX[m_act_val[d*4 +: 4]] : 7'h00;
    e_dp    = lit && m_act_dp[d];
    e_an_l  = ~e_an;
    e_seg_l = ~e_seg;
    e_dp_l  = ~e_dp;
    m_fs = (p == 63);
    if (p == 63 && m_pend) begin
      m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_pend = 0;
    end
    if (load) begin
      m_sh_val = value; m_sh_dp = dp_in; m_pend = 1;
    end
    p = (p + 1) % 64;
    #1;
    check("an_l",  an_l,  e_an_l);
    check("seg_l", seg_l, e_seg_l);
    check("dp_l",  dp_l,  e_dp_l);
    check("pend_l", pend_l, m_pend);
    check("fs_l",  fs_l,  m_fs);
    check("an_h",  an_h,  e_an);
    check("seg_h", seg_h, e_seg);
    check("dp_h",  dp_h,  e_dp);
    check("pend_h", pend_h, m_pend);
    check("fs_h",  fs_h,  m_fs);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Run until frame_start is seen, bounded to a little over one frame
  task automatic wait_frame();
    for (int k = 0; k < 70; k++) begin
      step();
      if (fs_l) break;
    end
    check("frame_start_seen", fs_l, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; value = '0; dp_in = '0; load = 1'b0;
    digit_en = 4'hF; blank_lz = 1'b0; brightness = 2'd3;
    model_reset();

    // Reset values
    #12;
    check("rst_an_l", an_l, 4'hF);
    check("rst_seg_l", seg_l, 7'h7F);
    check("rst_dp_l", dp_l, 1'b1);
    check("rst_pend", pend_l, 1'b0);
    check("rst_an_h", an_h, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    // Async reset asserted mid-slot takes effect immediately
    steps(37);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an_l", an_l, 4'hF);
    check("arst_seg_l", seg_l, 7'h7F);
    check("arst_dp_l", dp_l, 1'b1);
    check("arst_fs_l", fs_l, 1'b0);
    check("arst_an_h", an_h, 4'h0);
    check("arst_seg_h", seg_h, 7'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    steps(20);

    // Basic display
    do_load(16'h12AF, 4'b0010);
    check("basic_pending", pend_l, 1'b1);
    wait_frame();
    for (int i = 0; i < 12; i++) begin
      step();
      check("d0_an_lit", an_l, 4'b1110);
      check("d0_seg", seg_l, 7'b0001110);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("d0_deadtime", an_l, 4'b1111);
    end
    step();
    check("d1_an", an_l, 4'b1101);
    check("d1_seg", seg_l, 7'b0001000);
    check("d1_dp", dp_l, 1'b0);
    steps(80);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_frame();
    step();
    check("lz_d0_seg", seg_l, 7'b1000000);
    steps(70);
    do_load(16'h0000, 4'b0000);
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (an_l[3:1] != 3'b111) cnt++;
    end
    check("lz_zero_only_d0", cnt, 0);
    blank_lz = 1'b0;

    // Double buffer: mid-frame load waits for the wrap
    while (p != 20) step();
    do_load(16'h1111, 4'b0000);
    check("db_pending_set", pend_l, 1'b1);
    while (p != 0) step();
    check("db_pending_clr", pend_l, 1'b0);
    check("db_fs", fs_l, 1'b1);
    // Load on the wrap cycle stays pending for a full frame
    while (p != 63) step();
    do_load(16'h2222, 4'b0000);
    check("wrap_load_pending", pend_l, 1'b1);
    steps(63);
    check("wrap_load_still", pend_l, 1'b1);
    step();
    check("wrap_load_clr", pend_l, 1'b0);

    // Brightness and enables
    brightness = 2'd0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(); if (an_l != 4'hF) cnt++; end
    check("bright0_dark", cnt, 0);
    brightness = 2'd1;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(); if (an_l != 4'hF) cnt++; end
    check("bright1_lit", cnt, 16);
    brightness = 2'd3;
    digit_en = 4'b1011;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(); if (!an_l[2]) cnt++; end
    check("en_d2_dark", cnt, 0);
    digit_en = 4'hF;

    // Active-high instance shows an 8
    do_load(16'h0008, 4'b0000);
    wait_frame();
    step();
    check("ah_seg8", seg_h, 7'h7F);
    check("ah_an", an_h, 4'b0001);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      digit_en   = 4'($urandom);
      blank_lz   = 1'($urandom);
      brightness = BW'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_load(16'($urandom_range(0, 3) == 0 ? 16'h0 : $urandom & 32'h00FF_0F0F), 4'($urandom));
      steps($urandom_range(1, 90));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seven_seg_scanner
`default_nettype wire
